sim_run_controller: RTL and testbench



---
 rtl/sim_ctrl_pkg.sv | 23 ++
 rtl/cycle_budget_counter.sv | 44 ++++
 rtl/sim_run_controller.sv | 112 +++++++++++
 tb/tb_sim_run_controller.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/sim_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sim_ctrl_pkg
// Purpose  : Shared state and opcode encodings for the simulator run controller.
// Revision : 1.0 - initial release
// ============================================================================
package sim_ctrl_pkg;

  // Matches the 2-bit state convention used by the simulator core.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10,
    ST_DONE  = 2'b11
  } ctrl_state_t;

  localparam logic [1:0] OP_RUN   = 2'b00;
  localparam logic [1:0] OP_STEP  = 2'b01;
  localparam logic [1:0] OP_PAUSE = 2'b10;
  localparam logic [1:0] OP_ABORT = 2'b11;

endpackage
`default_nettype wire

// File: rtl/cycle_budget_counter.sv
`default_nettype none
// ============================================================================
// Module   : cycle_budget_counter
// Purpose  : Loadable down-counter of remaining budget paired with an up-counter
//            of issued cycles; load clears the up-counter.
// Revision : 1.0 - initial release
// ============================================================================
module cycle_budget_counter #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load,
  input  logic [W-1:0] load_value,
  input  logic         en,
  output logic [W-1:0] remaining,
  output logic [W-1:0] current,
  output logic         last
);

  localparam logic [W-1:0] c_one = {{(W-1){1'b0}}, 1'b1};

  logic [W-1:0] r_remaining;
  logic [W-1:0] r_current;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_remaining <= '0;
      r_current   <= '0;
    end else if (load) begin
      r_remaining <= load_value;
      r_current   <= '0;
    end else if (en) begin
      r_remaining <= r_remaining - c_one;
      r_current   <= r_current + c_one;
    end
  end

  assign remaining = r_remaining;
  assign current   = r_current;
  assign last      = (r_remaining == c_one);

endmodule
`default_nettype wire

// File: rtl/sim_run_controller.sv
`default_nettype none
// ============================================================================
// Module   : sim_run_controller
// Purpose  : Command-driven run/step/pause/abort sequencer gating the simulator
//            advance enable against a programmable cycle budget.
// Revision : 1.0 - initial release
// ============================================================================
module sim_run_controller
  import sim_ctrl_pkg::*;
#(
  parameter int MAX_CYCLE_WIDTH = 5
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [1:0]                 cmd_op,
  input  logic [MAX_CYCLE_WIDTH-1:0] cmd_cycles,
  output logic                       sim_en,
  output logic [1:0]                 state,
  output logic [MAX_CYCLE_WIDTH-1:0] current_cycle,
  output logic [MAX_CYCLE_WIDTH-1:0] remaining,
  output logic                       done
);

  ctrl_state_t r_state;
  logic        r_step_q;
  logic        r_done;

  logic w_accept;
  logic w_sim_en;
  logic w_load;
  logic w_last;

  assign cmd_ready = !r_step_q;
  assign w_accept  = cmd_valid && cmd_ready;
  // Decoded purely from registers so the command inputs never reach sim_en.
  assign w_sim_en  = (r_state == ST_RUN) || r_step_q;
  assign w_load    = w_accept && (cmd_op == OP_RUN) &&
                     ((r_state == ST_IDLE) || (r_state == ST_DONE));

  cycle_budget_counter #(
    .W (MAX_CYCLE_WIDTH)
  ) u_budget (
    .clk        (clk),
    .reset_n    (reset_n),
    .load       (w_load),
    .load_value (cmd_cycles),
    .en         (w_sim_en),
    .remaining  (remaining),
    .current    (current_cycle),
    .last       (w_last)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= ST_IDLE;
      r_step_q <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done   <= 1'b0;
      r_step_q <= 1'b0;
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (w_load) begin
            if (cmd_cycles == '0) begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= ST_RUN;
            end
          end
        end
        ST_RUN: begin
          // Budget exhaustion wins over any command on the same edge.
          if (w_last) begin
            r_state <= ST_DONE;
            r_done  <= 1'b1;
          end else if (w_accept && (cmd_op == OP_PAUSE)) begin
            r_state <= ST_PAUSE;
          end else if (w_accept && (cmd_op == OP_ABORT)) begin
            r_state <= ST_DONE;
            r_done  <= 1'b1;
          end
        end
        ST_PAUSE: begin
          if (r_step_q && w_last) begin
            r_state <= ST_DONE;
            r_done  <= 1'b1;
          end else if (w_accept) begin
            case (cmd_op)
              OP_RUN:   r_state <= ST_RUN;
              OP_STEP:  r_step_q <= 1'b1;
              OP_ABORT: begin
                r_state <= ST_DONE;
                r_done  <= 1'b1;
              end
              default: ;
            endcase
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign sim_en = w_sim_en;
  assign state  = r_state;
  assign done   = r_done;

endmodule
`default_nettype wire

// File: tb/tb_sim_run_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_sim_run_controller
// Purpose  : Directed and randomized self-checking bench for sim_run_controller.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sim_run_controller;

  localparam int W = 5;
  localparam logic [1:0] RUN = 2'b00, STEP = 2'b01, PAUSE = 2'b10, ABORT = 2'b11;
  localparam int S_IDLE = 0, S_RUN = 1, S_PAUSE = 2, S_DONE = 3;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [1:0]   cmd_op;
  logic [W-1:0] cmd_cycles;
  logic         sim_en;
  logic [1:0]   state;
  logic [W-1:0] current_cycle;
  logic [W-1:0] remaining;
  logic         done;

  sim_run_controller #(.MAX_CYCLE_WIDTH(W)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_op        (cmd_op),
    .cmd_cycles    (cmd_cycles),
    .sim_en        (sim_en),
    .state         (state),
    .current_cycle (current_cycle),
    .remaining     (remaining),
    .done          (done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int en_cnt = 0;
  int done_cnt = 0;

  // Reference model: mode, counters, pending step and done pulse.
  int m_mode, m_cur, m_rem;
  bit m_step, m_done;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = S_IDLE; m_cur = 0; m_rem = 0; m_step = 0; m_done = 0;
  endtask

  task automatic model_edge(input bit v, input logic [1:0] op, input int cyc);
    bit running, accepted, fire;
    running  = (m_mode == S_RUN) || m_step;
    accepted = v && !m_step;
    fire     = 0;
    m_done   = 0;
    if (m_mode == S_IDLE || m_mode == S_DONE) begin
      if (accepted && op == RUN) begin
        m_cur = 0;
        m_rem = cyc;
        if (cyc == 0) fire = 1; else m_mode = S_RUN;
      end
    end else if (m_mode == S_RUN) begin
      if (m_rem == 1) fire = 1;
      else if (accepted && op == PAUSE) m_mode = S_PAUSE;
      else if (accepted && op == ABORT) fire = 1;
    end else begin
      if (m_step && m_rem == 1) fire = 1;
      else if (accepted && op == RUN) m_mode = S_RUN;
      else if (accepted && op == ABORT) fire = 1;
    end
    m_step = (m_mode == S_PAUSE) && !fire && accepted && op == STEP;
    if (running) begin
      m_cur = (m_cur + 1) % (1 << W);
      m_rem = m_rem - 1;
    end
    if (fire) begin
      m_mode = S_DONE;
      m_done = 1;
    end
  endtask

  task automatic check_outputs();
    chk("state", 32'(state), 32'(m_mode));
    chk("sim_en", 32'(sim_en), 32'((m_mode == S_RUN) || m_step));
    chk("cmd_ready", 32'(cmd_ready), 32'(!m_step));
    chk("current_cycle", 32'(current_cycle), 32'(m_cur));
    chk("remaining", 32'(remaining), 32'(m_rem));
    chk("done", 32'(done), 32'(m_done));
    if (sim_en === 1'b1) en_cnt++;
    if (done === 1'b1) done_cnt++;
  endtask

  task automatic tick(input bit v, input logic [1:0] op, input int cyc);
    cmd_valid  = v;
    cmd_op     = op;
    cmd_cycles = W'(cyc);
    #1;
    check_outputs();
    @(posedge clk);
    model_edge(v, op, cyc);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(0, RUN, 0);
  endtask

  initial begin
    reset_n = 1'b0; cmd_valid = 1'b0; cmd_op = RUN; cmd_cycles = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_outputs();
    reset_n = 1'b1;

    // RUN 3 from IDLE
    en_cnt = 0; done_cnt = 0;
    tick(1, RUN, 3);
    idle(5);
    chk("run3_en_cycles", 32'(en_cnt), 32'd3);
    chk("run3_done_pulses", 32'(done_cnt), 32'd1);
    chk("run3_state", 32'(state), 32'd3);
    chk("run3_cur", 32'(current_cycle), 32'd3);
    chk("run3_rem", 32'(remaining), 32'd0);

    // RUN 0: straight to DONE
    en_cnt = 0; done_cnt = 0;
    tick(1, RUN, 0);
    chk("run0_state", 32'(state), 32'd3);
    idle(3);
    chk("run0_en_cycles", 32'(en_cnt), 32'd0);
    chk("run0_done_pulses", 32'(done_cnt), 32'd1);

    // Pause in 4th sim_en cycle, step, resume
    tick(1, RUN, 10);
    idle(3);
    tick(1, PAUSE, 0);
    chk("pause_state", 32'(state), 32'd2);
    chk("pause_cur", 32'(current_cycle), 32'd4);
    chk("pause_rem", 32'(remaining), 32'd6);
    idle(1);
    en_cnt = 0;
    tick(1, STEP, 0);
    tick(1, STEP, 0);  // offered while step_q is high; must not be accepted
    chk("step_en_cycles", 32'(en_cnt), 32'd1);
    chk("step_cur", 32'(current_cycle), 32'd5);
    en_cnt = 0; done_cnt = 0;
    tick(1, RUN, 20);
    idle(7);
    chk("resume_en_cycles", 32'(en_cnt), 32'd5);
    chk("resume_done_pulses", 32'(done_cnt), 32'd1);
    chk("resume_state", 32'(state), 32'd3);

    // ABORT in PAUSE after 2 of 8
    tick(1, RUN, 8);
    idle(1);
    tick(1, PAUSE, 0);
    idle(1);
    done_cnt = 0;
    tick(1, ABORT, 0);
    idle(1);
    chk("abort_done_pulses", 32'(done_cnt), 32'd1);
    chk("abort_state", 32'(state), 32'd3);
    chk("abort_rem", 32'(remaining), 32'd6);
    en_cnt = 0;
    tick(1, STEP, 0);
    idle(2);
    chk("abort_step_en", 32'(en_cnt), 32'd0);
    chk("abort_step_rem", 32'(remaining), 32'd6);

    // Budget exhaustion coinciding with PAUSE accept
    tick(1, RUN, 2);
    idle(1);
    done_cnt = 0;
    tick(1, PAUSE, 0);
    idle(1);
    chk("exhaust_state", 32'(state), 32'd3);
    chk("exhaust_done_pulses", 32'(done_cnt), 32'd1);

    // Asynchronous reset mid-RUN
    tick(1, RUN, 6);
    idle(2);
    #2;
    reset_n = 1'b0;
    #1;
    chk("areset_sim_en", 32'(sim_en), 32'd0);
    chk("areset_state", 32'(state), 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    chk("areset_ready", 32'(cmd_ready), 32'd1);
    chk("areset_cur", 32'(current_cycle), 32'd0);
    chk("areset_rem", 32'(remaining), 32'd0);

    // Randomized command traffic against the model
    for (int i = 0; i < 600; i++) begin
      tick(($urandom_range(0, 9) < 4), 2'($urandom_range(0, 3)),
           ($urandom_range(0, 7) == 0) ? $urandom_range(0, 31) : $urandom_range(0, 6));
    end
    idle(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
